// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between the load/store unit and
// data_mem_ctrl.
//   master modport (core side): drives req_valid, req_write, req_size,
//     req_signed, address, data_in; receives req_ready, resp_valid,
//     resp_err, data_out.
//   slave modport (memory side): the mirror image.
interface data_mem_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] address;
    logic [WIDTH-1:0]      data_in;
    logic                  resp_valid;
    logic                  resp_err;
    logic [WIDTH-1:0]      data_out;

    modport master (
        output req_valid, req_write, req_size, req_signed, address, data_in,
        input  req_ready, resp_valid, resp_err, data_out
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, address, data_in,
        output req_ready, resp_valid, resp_err, data_out
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed on-chip data memory with a valid/ready
// request port, configurable read latency, little-endian sub-word access
// and error flagging (unsupported size, misaligned, out of range).
// One request outstanding at a time.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (clears state and all storage)
//   bus   : data_mem_ctrl_if.slave (request fields in, response out)
// Optional feature macro: DMEM_SUBWORD_EN enables byte/halfword accesses
// and sub-word sign extension; without it sizes 0 and 1 are rejected.
module data_mem_ctrl #(
    parameter int DEPTH        = 256,
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [1:0]       cnt;
    logic [1:0]       cap_size;
    logic             cap_signed;
    logic [IW-1:0]    cap_addr;
    logic             ready_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] data_out_q;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Request checks on the live bus fields (evaluated at acceptance)
    logic [3:0] nbytes;
    logic       req_err;

    always_comb begin
        nbytes  = size_bytes(bus.req_size);
        req_err = 1'b0;
        if (bus.req_size == 2'd3 && WIDTH != 64)
            req_err = 1'b1;
`ifndef DMEM_SUBWORD_EN
        if (bus.req_size < 2'd2)
            req_err = 1'b1;
`endif
        if ((bus.address & ADDR_WIDTH'(nbytes - 4'd1)) != '0)
            req_err = 1'b1;
        if (({1'b0, bus.address} + (ADDR_WIDTH+1)'(nbytes)) > (ADDR_WIDTH+1)'(DEPTH))
            req_err = 1'b1;
    end

    // Read path: with single-cycle latency the read happens on the
    // acceptance edge, so it must use the live fields; otherwise it uses
    // the fields captured at acceptance.
    logic [IW-1:0]    rd_addr;
    logic [1:0]       rd_size;
    logic             rd_signed;
    logic [3:0]       rd_nbytes;
    logic [WIDTH-1:0] rd_raw;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] ext_mask;
    logic             sign_bit;

    always_comb begin
        if (state == IDLE) begin
            rd_addr   = IW'(bus.address);
            rd_size   = bus.req_size;
            rd_signed = bus.req_signed;
        end else begin
            rd_addr   = cap_addr;
            rd_size   = cap_size;
            rd_signed = cap_signed;
        end
        rd_nbytes = size_bytes(rd_size);
        rd_raw    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (i < 32'(rd_nbytes))
                rd_raw[8*i +: 8] = mem[rd_addr + IW'(i)];
        end
        case (rd_size)
            2'd0:    sign_bit = rd_raw[7];
            2'd1:    sign_bit = rd_raw[15];
            2'd2:    sign_bit = rd_raw[31];
            default: sign_bit = rd_raw[WIDTH-1];
        endcase
        // Ones above the loaded bytes; zero when the access fills the port
        ext_mask = {WIDTH{1'b1}} << {rd_nbytes, 3'b000};
        rd_data  = rd_raw;
`ifdef DMEM_SUBWORD_EN
        if (rd_signed && sign_bit)
            rd_data = rd_raw | ext_mask;
`else
        if (rd_signed && rd_size == 2'd2 && sign_bit)
            rd_data = rd_raw | ext_mask;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_size     <= '0;
            cap_signed   <= 1'b0;
            cap_addr     <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            data_out_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cap_size   <= bus.req_size;
                        cap_signed <= bus.req_signed;
                        cap_addr   <= IW'(bus.address);
                        ready_q    <= 1'b0;
                        if (req_err || bus.req_write) begin
                            if (!req_err) begin
                                for (int unsigned i = 0; i < NB; i++) begin
                                    if (i < 32'(nbytes))
                                        mem[IW'(bus.address) + IW'(i)] <= bus.data_in[8*i +: 8];
                                end
                            end
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= req_err;
                            data_out_q   <= '0;
                        end else if (READ_LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            data_out_q   <= rd_data;
                        end else begin
                            state <= WAIT;
                            cnt   <= 2'(READ_LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    // Counter would reach 0 on this edge: enter RESP and read
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        data_out_q   <= rd_data;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.data_out   = data_out_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised successor to the single-cycle data memory. It sits between `mips_core` (load/store unit) and on-chip byte storage and handles the whole request path: a valid/ready request port, configurable read latency, little-endian byte/halfword/word access with sign extension, and error flagging for misaligned or out-of-range accesses. It has one outstanding request at a time and is driven by an FSM.

## Interface
- `DEPTH`, 256: storage size in bytes. Must be a power of two and at least `WIDTH/8`.
- `WIDTH`, 32: data port width in bits. Legal values are 32 or 64.
- `ADDR_WIDTH`, 32: byte address width.
- `READ_LATENCY`, 1: cycles from read acceptance to response. Legal range is 1..4.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = doubleword (legal only when `WIDTH`=64).
- `req_signed` in 1: sign-extend load data. Ignored on stores.
- `address` in `ADDR_WIDTH`: byte address.
- `data_in` in `WIDTH`: store data, right-aligned (the low bytes are used).
- `resp_valid` out 1: one-cycle response pulse.
- `resp_err` out 1: the request was rejected. Qualified by `resp_valid`.
- `data_out` out `WIDTH`: load data, right-aligned and extended. Qualified by `resp_valid`.

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- `req_ready` = 1 only in IDLE.
- A request is accepted when `req_valid` && `req_ready` at a rising edge. Request fields are captured on that edge.
- Error check happens at acceptance, in this order:
  - unsupported size (3 with `WIDTH`=32);
  - misaligned access (`address` mod bytes ≠ 0);
  - out-of-range access (`address` + bytes > `DEPTH`).
- An erroring request does not modify storage. It goes straight to RESP with `resp_err`=1 and `data_out`=0.
- Stores:
  - the low `bytes` of `data_in` are written little-endian at `address` on the acceptance edge;
  - IDLE→RESP;
  - `data_out`=0 in the response.
- Loads:
  - IDLE→WAIT with the latency counter at `READ_LATENCY`-1;
  - if `READ_LATENCY`=1, IDLE→RESP directly;
  - WAIT decrements the counter and moves to RESP when it reaches 0;
  - storage is read at the edge entering RESP, so a load accepted after a store to the same address returns the new data;
  - bytes are assembled little-endian, then zero-extended or (if `req_signed`) sign-extended to `WIDTH`.
- RESP lasts exactly one cycle with `resp_valid`=1, then returns to IDLE. There is no response backpressure.
- `req_valid` held high while `req_ready`=0 has no effect. The request stays pending until the next IDLE cycle.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready`=1, `resp_valid`=0, `resp_err`=0, `data_out`=0;
  - all storage bytes are 0.
- Reset asserted mid-operation: the pending request is dropped and no response is issued. After release the block is in IDLE.
- For a request accepted at edge T:
  - store or error: `resp_valid` is high during cycle T+1;
  - load: `resp_valid` is high during cycle T+`READ_LATENCY`.
- `req_ready` is low from T+1 until the cycle after the response.
- Maximum throughput:
  - one store every 2 cycles;
  - one load every `READ_LATENCY`+1 cycles.
- `data_out` and `resp_err` hold their last response value until the next response.

## Configuration
- `DMEM_SUBWORD_EN` defined: byte and halfword sizes are supported as described above.
- `DMEM_SUBWORD_EN` undefined:
  - `req_size` 0 and 1 are treated as errors (`resp_err`=1, no write);
  - sign-extension logic is compiled out;
  - word and doubleword behaviour is unchanged.

## Test plan
- Reset then idle: `req_ready`=1, `resp_valid`=0. A word load from 0x00 returns 0x00000000 with `resp_err`=0.
- Store word 0xDEADBEEF at 0x10, then load byte 0x11 signed → 0xFFFFFFBE. Load byte 0x11 unsigned → 0x000000BE. Load half 0x12 signed → 0xFFFFDEAD.
- With `READ_LATENCY`=3, a load accepted at edge T: `resp_valid` is high only in cycle T+3, and `req_valid` held high is not re-accepted until T+4.
- Misaligned word load at 0x02 and word store at 0xFE (with `DEPTH`=256) → `resp_err`=1 one cycle later, and a following load from 0xFC shows storage unchanged.
- Assert `rst_n` during WAIT → no `resp_valid`, all storage reads back 0, and `req_ready`=1 immediately.
- With `DMEM_SUBWORD_EN` undefined, a byte store of 0xAA at 0x20 → `resp_err`=1, and a word load from 0x20 returns 0x00000000.
